// File: rtl/seq_mult_7bit.sv
// Sequential shift-and-add unsigned multiplier: one ripple-carry adder reused over WIDTH cycles.
// Start is accepted in idle; the product register updates on the last iteration, then done pulses.
module seq_mult_7bit #(
  parameter int unsigned WIDTH = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [2:0]           r_cnt;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_q;
  logic [WIDTH-1:0]     r_p;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;
  logic [2*WIDTH-1:0]   w_shift;
  logic                 w_last;

  assign w_last  = (r_cnt == 3'(WIDTH - 1));
  assign w_shift = {w_cout, w_sum, r_q[WIDTH-1:1]};

  // Ripple-carry adder; a zero multiplier bit gates the addend rather than bypassing the adder.
  always_comb begin
    logic v_c;
    w_addend = r_q[0] ? r_m : '0;
    w_sum    = '0;
    v_c      = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_sum[i] = r_p[i] ^ w_addend[i] ^ v_c;
      v_c      = (r_p[i] & w_addend[i]) | (v_c & (r_p[i] ^ w_addend[i]));
    end
    w_cout = v_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = StIdle;
    unique case (r_state)
      StIdle:  w_state_next = i_start ? StRun : StIdle;
      StRun:   w_state_next = w_last ? StDone : StRun;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_busy = (r_state == StRun);
    o_done = (r_state == StDone);
  end

  assign o_product = r_product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_q       <= '0;
      r_p       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (r_state == StIdle) begin
      if (i_start) begin
        r_m   <= i_a;
        r_q   <= i_b;
        r_p   <= '0;
        r_cnt <= '0;
      end
    end else if (r_state == StRun) begin
      // Carry out lands in the top of P so no partial-sum bit is lost.
      r_p   <= w_shift[2*WIDTH-1:WIDTH];
      r_q   <= w_shift[WIDTH-1:0];
      r_cnt <= r_cnt + 3'd1;
      if (w_last) begin
        r_product <= w_shift;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_7bit.sv
// Self-checking bench for seq_mult_7bit: timing-level reference model checked every cycle,
// plus directed literal checks and randomized operand/start stimulus.
module tb_seq_mult_7bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [6:0]  i_a = '0;
  logic [6:0]  i_b = '0;
  logic        o_busy;
  logic        o_done;
  logic [13:0] o_product;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  seq_mult_7bit #(.WIDTH(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_product (o_product)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: m_timer counts cycles since the accepting edge (-1 = idle); 1..7 busy, 8 = done.
  int          m_timer = -1;
  logic [13:0] m_pend = '0;
  logic [13:0] m_prod = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_timer <= -1;
      m_prod  <= '0;
    end else if (m_timer < 0) begin
      if (i_start) begin
        m_pend  <= {7'b0, i_a} * {7'b0, i_b};
        m_timer <= 1;
      end
    end else if (m_timer == 7) begin
      m_prod  <= m_pend;
      m_timer <= 8;
    end else if (m_timer == 8) begin
      m_timer <= -1;
    end else begin
      m_timer <= m_timer + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(o_busy), int'(m_timer >= 1 && m_timer <= 7));
      check("done", int'(o_done), int'(m_timer == 8));
      check("product", int'(o_product), int'(m_prod));
      check("busy_and_done", int'(o_busy & o_done), 0);
    end
  end

  task automatic run_op(input logic [6:0] a, input logic [6:0] b, input logic [13:0] exp,
                        input string name);
    int k;
    int nb;
    @(posedge clk); #1;
    i_a = a; i_b = b; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    k = 0;
    nb = 0;
    while (!o_done && k < 20) begin
      if (o_busy) nb++;
      @(posedge clk); #1;
      k++;
    end
    check({"done_seen_", name}, int'(o_done), 1);
    check({"busy_cycles_", name}, nb, 7);
    check({"product_", name}, int'(o_product), int'(exp));
    @(posedge clk); #1;
    check({"product_hold_", name}, int'(o_product), int'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    int last;
    logic [6:0] ra;
    logic [6:0] rb;

    #23;
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("reset_product", int'(o_product), 0);
    check("reset_busy", int'(o_busy), 0);

    run_op(7'd5, 7'd3, 14'h000F, "basic");
    run_op(7'h7F, 7'h7F, 14'h3F01, "max");
    run_op(7'h00, 7'h7F, 14'h0000, "zero");
    run_op(7'h01, 7'h7F, 14'h007F, "one");
    run_op(7'h40, 7'h40, 14'h1000, "pow2");

    // Start and operand changes during RUN must be ignored.
    @(posedge clk); #1;
    i_a = 7'd2; i_b = 7'd3; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 12; c++) begin
      if (o_done) begin
        nd++;
        check("ignore_product", int'(o_product), 16'h0006);
      end
      if (c == 1) begin i_start = 1'b1; i_a = 7'd9; i_b = 7'd9; end
      if (c == 2) i_start = 1'b0;
      if (c == 3) begin i_a = 7'($urandom); i_b = 7'($urandom); end
      @(posedge clk); #1;
    end
    check("ignore_done_count", nd, 1);

    // Back-to-back with start held high: one completion every 9 cycles.
    i_a = 7'd10; i_b = 7'd11; i_start = 1'b1;
    nd = 0;
    last = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (o_done) begin
        nd++;
        check("b2b_product", int'(o_product), 16'h006E);
        if (last >= 0) check("b2b_period", c - last, 9);
        last = c;
      end
    end
    check("b2b_done_count", nd, 4);
    i_start = 1'b0;
    repeat (12) @(posedge clk);

    // Asynchronous reset mid-RUN abandons the operation.
    @(posedge clk); #1;
    i_a = 7'h7F; i_b = 7'h7F; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_product", int'(o_product), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (o_done) nd++;
    end
    check("rst_no_done", nd, 0);
    run_op(7'd6, 7'd7, 14'h002A, "after_rst");

    for (int n = 0; n < 30; n++) begin
      ra = 7'($urandom);
      rb = 7'($urandom);
      run_op(ra, rb, {7'b0, ra} * {7'b0, rb}, "rand");
    end

    // Free-running random start/operands, checked by the per-cycle model.
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      i_start = ($urandom_range(0, 2) == 0);
      i_a = 7'($urandom);
      i_b = 7'($urandom);
    end
    i_start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
